// File: rtl/pool_window_scheduler_pkg.sv
// Shared definitions for the pooling stage.
// Holds the scheduler state encoding and the default feature-map geometry.
// The pooling datapath imports the same constants, so both sides agree on
// the frame shape without repeating the numbers.
package pool_window_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } pool_state_t;

    localparam int POOL_IMG_W_DEF = 24;
    localparam int POOL_IMG_H_DEF = 24;
    localparam int POOL_SIZE_DEF  = 2;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_window_scheduler_pos_counter.sv
// pool_pos_counter: pixel position tracking for the pooling scheduler.
// Tracks row, column and total beat count, and decodes the window-relative
// strobes from the counters *before* they advance on the current beat.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   clear          zero all counters (frame start)
//   beat           a pixel transfers this cycle
//   win_first      beat is the first pixel of its window
//   lb_wr, lb_rd   line-buffer write / read strobes
//   lb_addr        window column index (0 when no strobe is meaningful)
//   win_close      beat completes a full POOLxPOOL window
//   last_beat      beat is the final pixel of the frame
//   frame_full     every pixel of the frame has been accepted
module pool_pos_counter
    import pool_window_scheduler_pkg::*;
#(
    parameter int IMG_W = POOL_IMG_W_DEF,
    parameter int IMG_H = POOL_IMG_H_DEF,
    parameter int POOL  = POOL_SIZE_DEF,
    parameter int AW    = $clog2(IMG_W / POOL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          beat,
    output logic          win_first,
    output logic          lb_wr,
    output logic          lb_rd,
    output logic [AW-1:0] lb_addr,
    output logic          win_close,
    output logic          last_beat,
    output logic          frame_full
);

    localparam int CW     = cnt_width(IMG_W);
    localparam int RW     = cnt_width(IMG_H);
    localparam int BW     = cnt_width(IMG_W * IMG_H + 1);
    localparam int FRAME  = IMG_W * IMG_H;
    // Pixels at or beyond these bounds are remainder pixels: accepted but
    // never part of a window.
    localparam int GRID_W = (IMG_W / POOL) * POOL;
    localparam int GRID_H = (IMG_H / POOL) * POOL;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [BW-1:0] beat_q, beat_d;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        beat_d = beat_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            beat_d = '0;
        end else if (beat) begin
            beat_d = beat_q + 1'b1;
            if (int'(col_q) == IMG_W - 1) begin
                col_d = '0;
                row_d = (int'(row_q) == IMG_H - 1) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            beat_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            beat_q <= beat_d;
        end
    end

    int  col_ph;
    int  row_ph;
    logic live;

    always_comb begin
        col_ph     = int'(col_q) % POOL;
        row_ph     = int'(row_q) % POOL;
        // Strobes only exist for an actual beat inside the pooled grid.
        live       = beat && (int'(col_q) < GRID_W) && (int'(row_q) < GRID_H);
        win_first  = live && (row_ph == 0) && (col_ph == 0);
        lb_rd      = live && (col_ph == 0) && (row_ph != 0);
        lb_wr      = live && (col_ph == POOL - 1) && (row_ph != POOL - 1);
        win_close  = live && (col_ph == POOL - 1) && (row_ph == POOL - 1);
        lb_addr    = live ? AW'(int'(col_q) / POOL) : '0;
        last_beat  = beat && (int'(beat_q) == FRAME - 1);
        frame_full = (int'(beat_q) == FRAME);
    end

endmodule

// File: rtl/pool_window_scheduler.sv
// pool_window_scheduler: position-exact control for the second pooling stage.
// Accepts one feature map pixel per beat, drives line-buffer strobes for the
// comparator datapath and presents each completed window as Cal_Valid,
// stalling input until the result is taken.
// Ports:
//   S_AXIS_ACLK / S_AXIS_ARESET   clock, async active-high reset
//   Start                         begin a frame (honoured only when idle)
//   Din_Valid / Din_Ready         pixel handshake
//   Win_First, Lb_Wr_En, Lb_Rd_En, Lb_Addr   per-beat datapath strobes
//   Cal_Valid / Cal_Ready         pooled result handshake
//   Busy                          frame in progress
//   Frame_Done                    one-cycle pulse after the frame completes
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high; valid never depends on ready.
module pool_window_scheduler
    import pool_window_scheduler_pkg::*;
#(
    parameter int IMG_W = POOL_IMG_W_DEF,
    parameter int IMG_H = POOL_IMG_H_DEF,
    parameter int POOL  = POOL_SIZE_DEF,
    parameter int AW    = $clog2(IMG_W / POOL)
) (
    input  logic          S_AXIS_ACLK,
    input  logic          S_AXIS_ARESET,
    input  logic          Start,
    input  logic          Din_Valid,
    output logic          Din_Ready,
    output logic          Win_First,
    output logic          Lb_Wr_En,
    output logic          Lb_Rd_En,
    output logic [AW-1:0] Lb_Addr,
    output logic          Cal_Valid,
    input  logic          Cal_Ready,
    output logic          Busy,
    output logic          Frame_Done
);

    pool_state_t state_q, state_d;

    logic beat;
    logic clear;
    logic win_close;
    logic last_beat;
    logic frame_full;

    assign beat  = Din_Valid && Din_Ready;
    assign clear = (state_q == ST_IDLE) && Start;

    pool_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .POOL  (POOL),
        .AW    (AW)
    ) u_pos (
        .clk        (S_AXIS_ACLK),
        .rst        (S_AXIS_ARESET),
        .clear      (clear),
        .beat       (beat),
        .win_first  (Win_First),
        .lb_wr      (Lb_Wr_En),
        .lb_rd      (Lb_Rd_En),
        .lb_addr    (Lb_Addr),
        .win_close  (win_close),
        .last_beat  (last_beat),
        .frame_full (frame_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (Start) state_d = ST_RUN;
            ST_RUN: begin
                // A closing window outranks frame end so the last result is
                // still presented when the final beat closes it.
                if (win_close)      state_d = ST_HOLD;
                else if (last_beat) state_d = ST_DONE;
            end
            ST_HOLD: begin
                // Trailing remainder pixels keep the frame open after the
                // final window is consumed.
                if (Cal_Ready) state_d = frame_full ? ST_DONE : ST_RUN;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        Din_Ready  = (state_q == ST_RUN);
        Cal_Valid  = (state_q == ST_HOLD);
        Busy       = (state_q != ST_IDLE);
        Frame_Done = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_pool_window_scheduler.sv
module tb_pool_window_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 4x4 instance
    logic start4, dv4, cr4;
    logic dr4, wf4, wr4, rd4, cv4, busy4, fd4;
    logic [0:0] addr4;

    // 5x5 instance (remainder row and column)
    logic start5, dv5, cr5;
    logic dr5, wf5, wr5, rd5, cv5, busy5, fd5;
    logic [0:0] addr5;

    pool_window_scheduler #(.IMG_W(4), .IMG_H(4), .POOL(2)) dut4 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .Start(start4),
        .Din_Valid(dv4), .Din_Ready(dr4), .Win_First(wf4),
        .Lb_Wr_En(wr4), .Lb_Rd_En(rd4), .Lb_Addr(addr4),
        .Cal_Valid(cv4), .Cal_Ready(cr4), .Busy(busy4), .Frame_Done(fd4)
    );

    pool_window_scheduler #(.IMG_W(5), .IMG_H(5), .POOL(2)) dut5 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .Start(start5),
        .Din_Valid(dv5), .Din_Ready(dr5), .Win_First(wf5),
        .Lb_Wr_En(wr5), .Lb_Rd_En(rd5), .Lb_Addr(addr5),
        .Cal_Valid(cv5), .Cal_Ready(cr5), .Busy(busy5), .Frame_Done(fd5)
    );

    typedef struct {
        logic       wf;
        logic       wr;
        logic       rd;
        logic [0:0] addr;
        logic       close;
    } beat_vec_t;

    beat_vec_t vec4[16];
    int close5[4] = '{7, 9, 17, 19};   // 1-indexed closing beats on 5x5

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];             // expected Cal_Valid rise cycles

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One 4x4 frame with continuous Din_Valid.
    //   stall:         cycles Cal_Ready is held low on the first window
    //   start_in_run:  pulse Start mid-frame
    //   start_in_done: pulse Start during the Frame_Done cycle
    //   abort_after:   stop driving after this many beats (0 = full frame)
    task automatic frame4(input int stall, input bit start_in_run,
                          input bit start_in_done, input int abort_after);
        int  beats = 0;
        int  wins = 0;
        int  stall_left = stall;
        int  last_consume = -100;
        int  budget = 0;
        bit  prev_cv = 0;
        bit  prev_stall = 0;
        bit  consumed_prev = 0;
        bit  done_seen = 0;
        exp_q.delete();
        @(negedge clk);
        start4 = 1'b1; dv4 = 1'b1; cr4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        while (!done_seen && budget < 200) begin
            budget++;
            start4 = (start_in_run && beats == 5) ? 1'b1 : 1'b0;
            if (cv4 && wins == 0 && stall_left > 0) begin
                cr4 = 1'b0;
                stall_left--;
            end else begin
                cr4 = 1'b1;
            end
            #1;
            if (prev_stall) chk("hold_cal_valid", cv4, 1);
            if (cv4 && !cr4) chk("stall_din_ready", dr4, 0);
            if (consumed_prev && wins < 4) begin
                chk("ready_after_consume", dr4, 1);
                chk("cal_valid_drop", cv4, 0);
            end
            if (dr4 && dv4) begin
                chk("win_first", wf4, vec4[beats].wf);
                chk("lb_wr_en", wr4, vec4[beats].wr);
                chk("lb_rd_en", rd4, vec4[beats].rd);
                chk("lb_addr", addr4, vec4[beats].addr);
                if (vec4[beats].close) exp_q.push_back(16'(cyc + 1));
                beats++;
            end else begin
                chk("idle_strobes", {wf4, wr4, rd4, addr4}, 0);
            end
            if (cv4 && !prev_cv) begin
                if (exp_q.size() == 0) chk("cal_valid_unexpected", 1, 0);
                else chk("cal_valid_rise", cyc, exp_q.pop_front());
            end
            consumed_prev = cv4 && cr4;
            if (consumed_prev) begin
                wins++;
                last_consume = cyc;
            end
            if (fd4) begin
                done_seen = 1;
                chk("frame_done_timing", cyc, last_consume + 1);
                chk("frame_beats", beats, 16);
            end
            prev_cv    = cv4;
            prev_stall = cv4 && !cr4;
            if (abort_after > 0 && beats == abort_after) return;
            if (!done_seen) @(negedge clk);
        end
        chk("frame4_finished", done_seen, 1);
        // Still inside the Frame_Done cycle: optional stray Start.
        start4 = start_in_done;
        @(negedge clk);
        start4 = 1'b0;
        #1;
        chk("frame_done_pulse", fd4, 0);
        chk("idle_after_done", {busy4, dr4}, 0);
        chk("windows4", wins, 4);
        chk("stall_cycles", stall_left, 0);
        chk("queue_empty4", exp_q.size(), 0);
    endtask

    task automatic frame5();
        int beats = 0;
        int wins = 0;
        int last_beat_cyc = -100;
        int budget = 0;
        bit prev_cv = 0;
        bit done_seen = 0;
        exp_q.delete();
        @(negedge clk);
        start5 = 1'b1; dv5 = 1'b1; cr5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        while (!done_seen && budget < 200) begin
            budget++;
            #1;
            if (dr5 && dv5) begin
                if (beats / 5 == 4 || beats % 5 == 4)
                    chk("remainder_strobes", {wf5, wr5, rd5, addr5}, 0);
                foreach (close5[k])
                    if (close5[k] == beats + 1) exp_q.push_back(16'(cyc + 1));
                beats++;
                last_beat_cyc = cyc;
            end
            if (cv5 && !prev_cv) begin
                if (exp_q.size() == 0) chk("cal_valid5_unexpected", 1, 0);
                else chk("cal_valid5_rise", cyc, exp_q.pop_front());
            end
            if (cv5 && cr5) wins++;
            if (fd5) begin
                done_seen = 1;
                chk("frame5_done_timing", cyc, last_beat_cyc + 1);
                chk("frame5_beats", beats, 25);
            end
            prev_cv = cv5;
            if (!done_seen) @(negedge clk);
        end
        chk("frame5_finished", done_seen, 1);
        chk("windows5", wins, 4);
        chk("queue_empty5", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start4 = 0; dv4 = 0; cr4 = 0;
        start5 = 0; dv5 = 0; cr5 = 0;

        // Expected 4x4 strobes, rows 0-1 by hand; rows 2-3 repeat them.
        vec4[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec4[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec4[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec4[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec4[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vec4[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vec4[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vec4[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) vec4[i + 8] = vec4[i];

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs4", {dr4, wf4, wr4, rd4, addr4, cv4, busy4, fd4}, 0);
        chk("reset_outputs5", {dr5, wf5, wr5, rd5, addr5, cv5, busy5, fd5}, 0);
        @(negedge clk);
        rst = 1'b0;

        frame4(0, 1'b0, 1'b0, 0);       // nominal throughput and strobes
        frame4(5, 1'b0, 1'b0, 0);       // back-pressure on first window
        frame5();                        // remainder row/column

        frame4(0, 1'b0, 1'b0, 7);       // abandon after beat 7
        @(negedge clk);
        dv4 = 1'b0;
        rst = 1'b1;
        #1;
        chk("midframe_reset", {dr4, wf4, wr4, rd4, addr4, cv4, busy4, fd4}, 0);
        @(negedge clk);
        rst = 1'b0;
        frame4(0, 1'b0, 1'b0, 0);       // clean frame after reset

        frame4(0, 1'b1, 1'b1, 0);       // stray Start in RUN and DONE

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
